tiger_muldiv_unit: RTL and testbench

//  Parametrised HI/LO multiply/divide unit for the Tiger execute stage. Executes

---
 rtl/tiger_muldiv_if.sv | 24 ++
 rtl/tiger_muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_tiger_muldiv_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/tiger_muldiv_if.sv
// Issue/response bundle between the Tiger execute stage and the HI/LO multiply/divide unit.
// The execute stage is the master; the unit is the slave.
interface tiger_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [WIDTH-1:0] mf_data;
  logic             stall_rq;
  logic             busy;

  modport master (
    output stall, op_valid, op, rs, rt,
    input  mf_data, stall_rq, busy
  );

  modport slave (
    input  stall, op_valid, op, rs, rt,
    output mf_data, stall_rq, busy
  );
endinterface

// File: rtl/tiger_muldiv_unit.sv
// HI/LO multiply/divide unit: registered multiply with configurable latency, radix-2
// restoring divider (one quotient bit per cycle), MTxx writes and combinational MFxx reads.
module tiger_muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 1
) (
  input logic           clk,
  input logic           reset,
  tiger_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO
  } op_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   quo_q, rem_q, dsr_q;
  logic               neg_quo_q, neg_rem_q, div_zero_q;

  op_t                op_in;
  logic               accept;
  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_now;
  logic [WIDTH:0]     rem_sh, diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx, quo_nx, quo_fix, rem_fix;

  assign op_in        = op_t'(bus.op);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.stall_rq = bus.op_valid & bus.busy;
  assign accept       = bus.op_valid & ~bus.stall & ~bus.stall_rq;

  // Signedness comes from op[0]: MULT/DIV are even, MULTU/DIVU odd.
  assign is_signed = ~bus.op[0];
  assign a_neg     = is_signed & bus.rs[WIDTH-1];
  assign b_neg     = is_signed & bus.rt[WIDTH-1];
  assign a_mag     = a_neg ? -bus.rs : bus.rs;
  assign b_mag     = b_neg ? -bus.rt : bus.rt;
  assign prod_now  = {{WIDTH{a_neg}}, bus.rs} * {{WIDTH{b_neg}}, bus.rt};

  // One restoring step: the dividend shifts out of quo_q MSB-first while quotient bits enter the LSB.
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, dsr_q};
  assign ge      = ~diff[WIDTH];
  assign rem_nx  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx  = {quo_q[WIDTH-2:0], ge};

  // Divide by zero leaves the dividend magnitude in rem_q, so the sign fix restores HI=rs.
  assign quo_fix = div_zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    bus.mf_data = '0;
    case (op_in)
      OP_MFHI: bus.mf_data = hi_q;
      OP_MFLO: bus.mf_data = lo_q;
      default: bus.mf_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if ((op_in == OP_MULT || op_in == OP_MULTU) && MUL_LATENCY > 1) state_d = S_MUL;
          else if (op_in == OP_DIV || op_in == OP_DIVU)                    state_d = S_DIV;
        end
      end
      S_MUL:   if (cnt_q == '0) state_d = S_IDLE;
      S_DIV:   if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      prod_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dsr_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (op_in)
              OP_MULT, OP_MULTU: begin
                if (MUL_LATENCY == 1) begin
                  {hi_q, lo_q} <= prod_now;
                end else begin
                  prod_q <= prod_now;
                  // cnt counts the busy cycles still to go after the first one.
                  cnt_q  <= CW'(MUL_LATENCY > 1 ? MUL_LATENCY - 2 : 0);
                end
              end
              OP_DIV, OP_DIVU: begin
                quo_q      <= a_mag;
                rem_q      <= '0;
                dsr_q      <= b_mag;
                neg_quo_q  <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                div_zero_q <= (bus.rt == '0);
                cnt_q      <= CW'(WIDTH - 1);
              end
              OP_MTHI: hi_q <= bus.rs;
              OP_MTLO: lo_q <= bus.rs;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt_q == '0) {hi_q, lo_q} <= prod_q;
          else             cnt_q <= cnt_q - CW'(1);
        end
        S_DIV: begin
          quo_q <= quo_nx;
          rem_q <= rem_nx;
          cnt_q <= cnt_q - CW'(1);
        end
        S_FIX: begin
          lo_q <= quo_fix;
          hi_q <= rem_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tiger_muldiv_unit.sv
// Self-checking bench for tiger_muldiv_unit: directed cases plus randomized ops checked
// against an arithmetic HI/LO reference model.
module tb_tiger_muldiv_unit;

  localparam logic [31:0] MIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  tiger_muldiv_if #(.WIDTH(32)) bus ();
  tiger_muldiv_if #(.WIDTH(32)) bus1 ();

  tiger_muldiv_unit #(.WIDTH(32), .MUL_LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  tiger_muldiv_unit #(.WIDTH(32), .MUL_LATENCY(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: HI/LO effect of an op, from plain integer arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    case (o)
      3'd0: begin
        sp = longint'(int'(a)) * longint'(int'(b));
        m_hi = sp[63:32]; m_lo = sp[31:0];
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      3'd2: begin
        if (b == 0)                        begin m_lo = '1;  m_hi = a; end
        else if (a == MIN && b == '1)      begin m_lo = MIN; m_hi = 0; end
        else begin
          m_lo = 32'(int'(a) / int'(b));
          m_hi = 32'(int'(a) % int'(b));
        end
      end
      3'd3: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic read_hilo(input string tag);
    bus.op_valid = 1'b1;
    bus.op = 3'd6; #1;
    check({tag, "_hi"}, bus.mf_data, m_hi);
    bus.op = 3'd7; #1;
    check({tag, "_lo"}, bus.mf_data, m_lo);
    bus.op_valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy, input string tag);
    int n;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = o; bus.rs = a; bus.rt = b; bus.stall = 1'b0;
    #1 check({tag, "_srq"}, 32'(bus.stall_rq), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0; bus.rs = $urandom; bus.rt = $urandom;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      bus.stall = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.stall = 1'b0;
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    model(o, a, b);
    read_hilo(tag);
  endtask

  initial begin
    int n;
    logic [2:0]  o;
    logic [31:0] a, b;
    int          eb;

    reset = 1'b1;
    bus.stall = 0;  bus.op_valid = 0;  bus.op = 0;  bus.rs = 0;  bus.rt = 0;
    bus1.stall = 0; bus1.op_valid = 0; bus1.op = 0; bus1.rs = 0; bus1.rt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 3'd6; #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_stall_rq", 32'(bus.stall_rq), 32'd0);
    check("rst_mf_hi", bus.mf_data, 32'd0);
    bus.op = 3'd7; #1;
    check("rst_mf_lo", bus.mf_data, 32'd0);
    bus.op_valid = 1'b0;
    reset = 1'b0;
    m_hi = 0; m_lo = 0;

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1, "mult_neg2x3");
    check("mult_hi_const", m_hi, 32'hFFFF_FFFF);
    check("mult_lo_const", m_lo, 32'hFFFF_FFFA);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "multu_max");

    // DIV -7/2 with MFLO waiting behind it.
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 3'd2; bus.rs = -32'sd7; bus.rt = 32'd2;
    @(posedge clk);
    @(negedge clk);
    bus.op = 3'd7; bus.rs = $urandom; bus.rt = $urandom; #1;
    n = 0;
    while (bus.stall_rq && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
    check("div_stall_rq_cycles", 32'(n), 32'd33);
    check("div_mflo", bus.mf_data, 32'hFFFF_FFFD);
    @(posedge clk);
    @(negedge clk);
    bus.op = 3'd6; #1;
    check("div_mfhi", bus.mf_data, 32'hFFFF_FFFF);
    bus.op_valid = 1'b0;
    model(3'd2, -32'sd7, 32'd2);

    run_op(3'd3, 32'd100, 32'd0, 33, "divu_by_zero");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 33, "div_neg_by_zero");
    run_op(3'd2, MIN, 32'hFFFF_FFFF, 33, "div_overflow");
    run_op(3'd3, 32'hFFFF_FFFF, 32'd7, 33, "divu_max_by7");

    // MTHI blocked by an external stall, then accepted.
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 3'd4; bus.rs = 32'h1234; bus.stall = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.stall = 1'b0; bus.op_valid = 1'b0;
    read_hilo("mthi_stalled");
    run_op(3'd4, 32'h1234, 32'd0, 0, "mthi");
    check("mthi_const", m_hi, 32'h1234);
    run_op(3'd5, 32'hCAFE_F00D, 32'd0, 0, "mtlo");

    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = MIN; b = '1; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'sd3;
        default: ;
      endcase
      eb = (o < 3'd2) ? 1 : (o < 3'd4) ? 33 : 0;
      run_op(o, a, b, eb, $sformatf("rand%0d_op%0d", i, o));
    end

    // Reset ten cycles into a divide.
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 3'd2; bus.rs = 32'd1000; bus.rt = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_busy", 32'(bus.busy), 32'd0);
    m_hi = 0; m_lo = 0;
    read_hilo("mid_reset");
    run_op(3'd0, 32'd12345, 32'hFFFF_FF00, 1, "mult_after_reset");

    // Single-cycle multiplier: result lands at the accept edge, busy never rises.
    @(negedge clk);
    bus1.op_valid = 1'b1; bus1.op = 3'd1; bus1.rs = 32'hFFFF_FFFF; bus1.rt = 32'hFFFF_FFFF;
    #1 check("lat1_srq", 32'(bus1.stall_rq), 32'd0);
    @(posedge clk); #1;
    check("lat1_busy", 32'(bus1.busy), 32'd0);
    bus1.op = 3'd6; #1;
    check("lat1_hi", bus1.mf_data, 32'hFFFF_FFFE);
    bus1.op = 3'd7; #1;
    check("lat1_lo", bus1.mf_data, 32'h0000_0001);
    bus1.op_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
